// File: rtl/yags_predictor.sv
// ---------------------------------------------------------------------------
// yags_predictor
//
// YAGS conditional-branch direction predictor. A choice PHT indexed by PC
// gives a per-branch bias. Two direction caches, indexed by PC XOR global
// history and tagged with low PC bits, record only the exceptions to that
// bias. When the bias is taken the NT-cache is consulted. When the bias is
// not taken the T-cache is consulted.
//
// Lookup is purely combinational from fetch_pc/GHR. Training happens on the
// rising clock edge, using the history snapshot returned with the resolved
// branch. All tables are flops and are cleared by an asynchronous reset.
//
// Ports
//   clk            in  1          clock, all state updates on posedge
//   rst            in  1          asynchronous, active-low reset
//   fetch_pc       in  32         PC being predicted
//   GHR            in  GHR_size   live global history
//   predict_taken  out 1          direction prediction (combinational)
//   pred_cache_hit out 1          consulted cache supplied the prediction
//   upd_valid      in  1          resolved branch presented for training
//   upd_pc         in  32         PC of the resolved branch
//   upd_ghr        in  GHR_size   history snapshot from prediction time
//   upd_taken      in  1          resolved outcome
// ---------------------------------------------------------------------------
module yags_predictor #(
    parameter int GHR_size   = 10,
    parameter int CHOICE_IDX = 10,
    parameter int TAG_W      = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         fetch_pc,
    input  logic [GHR_size-1:0] GHR,
    output logic                predict_taken,
    output logic                pred_cache_hit,
    input  logic                upd_valid,
    input  logic [31:0]         upd_pc,
    input  logic [GHR_size-1:0] upd_ghr,
    input  logic                upd_taken
);

    localparam int CHOICE_N = 1 << CHOICE_IDX;
    localparam int CACHE_N  = 1 << GHR_size;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        logic [1:0]       ctr;
    } cache_entry_t;

    // Two-bit saturating step toward the given direction.
    function automatic logic [1:0] sat_step(input logic [1:0] c, input logic up);
        logic [1:0] r;
        r = c;
        if (up) begin
            if (c != 2'b11) r = c + 2'b01;
        end else begin
            if (c != 2'b00) r = c - 2'b01;
        end
        return r;
    endfunction

    // -----------------------------------------------------------------------
    // Table state
    // -----------------------------------------------------------------------
    logic [1:0]   choice_q   [CHOICE_N];
    cache_entry_t t_cache_q  [CACHE_N];
    cache_entry_t nt_cache_q [CACHE_N];

    // Only a subset of the PC bits feeds the tables; the rest are folded
    // into a deliberately unused signal.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{fetch_pc, upd_pc};

    // -----------------------------------------------------------------------
    // Lookup path
    // -----------------------------------------------------------------------
    logic [CHOICE_IDX-1:0] lk_choice_idx;
    logic [GHR_size-1:0]   lk_cache_idx;
    logic [TAG_W-1:0]      lk_tag;
    logic                  lk_bias;
    cache_entry_t          lk_entry;
    logic                  lk_hit;

    assign lk_choice_idx = fetch_pc[CHOICE_IDX+1:2];
    assign lk_cache_idx  = fetch_pc[GHR_size+1:2] ^ GHR;
    assign lk_tag        = fetch_pc[TAG_W+1:2];
    assign lk_bias       = choice_q[lk_choice_idx][1];
    assign lk_entry      = lk_bias ? nt_cache_q[lk_cache_idx] : t_cache_q[lk_cache_idx];
    assign lk_hit        = lk_entry.valid && (lk_entry.tag == lk_tag);

    assign predict_taken  = lk_hit ? lk_entry.ctr[1] : lk_bias;
    assign pred_cache_hit = lk_hit;

    // -----------------------------------------------------------------------
    // Update path (uses the returned history snapshot, never the live GHR)
    // -----------------------------------------------------------------------
    logic [CHOICE_IDX-1:0] up_choice_idx;
    logic [GHR_size-1:0]   up_cache_idx;
    logic [TAG_W-1:0]      up_tag;
    logic                  up_bias;
    cache_entry_t          up_entry;
    logic                  up_hit;
    logic                  cache_we;
    logic                  t_we;
    logic                  nt_we;
    logic                  choice_hold;
    logic                  choice_we;
    cache_entry_t          cache_d;
    logic [1:0]            choice_d;

    assign up_choice_idx = upd_pc[CHOICE_IDX+1:2];
    assign up_cache_idx  = upd_pc[GHR_size+1:2] ^ upd_ghr;
    assign up_tag        = upd_pc[TAG_W+1:2];
    assign up_bias       = choice_q[up_choice_idx][1];
    assign up_entry      = up_bias ? nt_cache_q[up_cache_idx] : t_cache_q[up_cache_idx];
    assign up_hit        = up_entry.valid && (up_entry.tag == up_tag);

    always_comb begin
        cache_d     = up_entry;
        cache_we    = 1'b0;
        choice_hold = 1'b0;
        if (up_hit) begin
            // Train the exception entry; tag and valid stay as they are.
            cache_d.ctr = sat_step(up_entry.ctr, upd_taken);
            cache_we    = upd_valid;
        end else if (upd_taken != up_bias) begin
            // Outcome disagreed with the bias: record a new exception,
            // starting weakly in the observed direction.
            cache_d.valid = 1'b1;
            cache_d.tag   = up_tag;
            cache_d.ctr   = upd_taken ? 2'b10 : 2'b01;
            cache_we      = upd_valid;
        end
        // When the cache already covered this exception correctly, leave the
        // bias alone so the branch keeps routing to the same cache.
        if ((upd_taken != up_bias) && up_hit && (up_entry.ctr[1] == upd_taken)) begin
            choice_hold = 1'b1;
        end
    end

    assign t_we      = cache_we && !up_bias;
    assign nt_we     = cache_we && up_bias;
    assign choice_we = upd_valid && !choice_hold;
    assign choice_d  = sat_step(choice_q[up_choice_idx], upd_taken);

    // -----------------------------------------------------------------------
    // State registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CHOICE_N; i++) begin
                choice_q[i] <= 2'b01;
            end
        end else if (choice_we) begin
            choice_q[up_choice_idx] <= choice_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CACHE_N; i++) begin
                t_cache_q[i] <= '0;
            end
        end else if (t_we) begin
            t_cache_q[up_cache_idx] <= cache_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CACHE_N; i++) begin
                nt_cache_q[i] <= '0;
            end
        end else if (nt_we) begin
            nt_cache_q[up_cache_idx] <= cache_d;
        end
    end

endmodule

// File: doc/yags_predictor.md
# yags_predictor

YAGS direction predictor, directly downstream of the global history register. It combines the fetch PC with the current `GHR` value to produce a same-cycle taken/not-taken prediction for the fetch stage. It trains its tables one clock later, using the resolved outcome and the history snapshot that the execute stage returns. All table state is held in flops inside this block.

## Interface
- `GHR_size`, 10: history width. Also sets the index width of the T-cache and NT-cache, which have 2^GHR_size entries each.
- `CHOICE_IDX`, 10: choice-PHT index width (2^CHOICE_IDX entries of 2-bit counters).
- `TAG_W`, 6: cache tag width.

Ports:
- `clk` in 1: single clock; all state updates on posedge.
- `rst` in 1: asynchronous, active-low reset.
- `fetch_pc` in 32: PC of the instruction being predicted.
- `GHR` in GHR_size: current global history from the history register.
- `predict_taken` out 1: direction prediction for `fetch_pc`, combinational.
- `pred_cache_hit` out 1: high when the consulted cache produced the prediction, combinational.
- `upd_valid` in 1: a resolved conditional branch is presented for training.
- `upd_pc` in 32: PC of the resolved branch.
- `upd_ghr` in GHR_size: GHR value captured when that branch was predicted.
- `upd_taken` in 1: actual branch outcome.

## Operation
Index and tag rules (identical for lookup and update):
- Choice index = pc[CHOICE_IDX+1:2].
- Cache index = pc[GHR_size+1:2] XOR ghr.
- Tag = pc[TAG_W+1:2].

Entry formats:
- Choice entry: 2-bit saturating counter. bias = ctr[1].
- Cache entry: {valid, tag[TAG_W-1:0], ctr[1:0]}.

Lookup (pure combinational, reads current state):
- If bias = 1, consult the NT-cache; if bias = 0, consult the T-cache.
- Hit = valid and tag equal.
- On hit: `predict_taken` = cache ctr[1] and `pred_cache_hit` = 1.
- On miss: `predict_taken` = bias and `pred_cache_hit` = 0.

Update, on posedge when `upd_valid` = 1. Recompute bias and hit from `upd_pc`/`upd_ghr`, then:
- **Cache hit:** move the consulted entry's counter toward `upd_taken` (saturating at 00 and 11). Tag and valid are unchanged.
- **Cache miss and `upd_taken` != bias:** allocate in the consulted cache. Set valid = 1, write the tag, and set ctr = 10 if taken, 01 if not taken. Any existing entry is overwritten with no replacement policy.
- **Cache miss and `upd_taken` == bias:** no cache write.
- **Choice counter:** move toward `upd_taken` (saturating). The one exception: if bias != `upd_taken` and the cache hit predicted `upd_taken` correctly, the choice counter is held.
- The non-consulted cache is never written.
- `upd_valid` = 0: no state change.

Reset (`rst` = 0, asynchronous):
- All choice counters go to 01 (weakly not taken).
- All cache valid bits clear; cache ctr and tag go to 0.
- Resulting outputs: `predict_taken` = 0 and `pred_cache_hit` = 0 for every PC/GHR.
- Reset asserted during an update cycle discards that update.

## Timing
- Prediction latency is 0 cycles: `predict_taken` and `pred_cache_hit` are valid combinationally from `fetch_pc`/`GHR`.
- Update latency is 1 cycle: an update presented in cycle N is visible to lookups from cycle N+1.
- Lookup and update hitting the same entry in the same cycle: the lookup returns the pre-update value (no bypass).
- The GHR register shifts on negedge. This block samples nothing on negedge and treats `GHR` as stable across the posedge.
- `upd_ghr` must be the snapshot taken at prediction time. The block never reads the live `GHR` for training.
- At most one update per cycle. There is no backpressure; every `upd_valid` cycle is accepted.

## Test plan
1. **Reset lookup:** release reset; `fetch_pc`=0x100, `GHR`=0 -> `predict_taken`=0, `pred_cache_hit`=0.
2. **T-cache allocation:** one update with `upd_pc`=0x100, `upd_ghr`=0, taken=1 -> T-cache[0x40] = {1, tag 0x00, 10}; choice[0x40] = 10. The next lookup of 0x100/0 -> bias taken, NT miss, `predict_taken`=1, `pred_cache_hit`=0.
3. **NT-cache allocation:** continuing, update 0x100/0 with taken=0 -> NT-cache[0x40] = {1, 0x00, 01}; choice[0x40] = 01. The next lookup -> T-cache hit, `predict_taken`=1, `pred_cache_hit`=1.
4. **Choice hold:** continuing, update 0x100/0 with taken=1 -> T-cache[0x40] ctr 10 -> 11; choice[0x40] stays 01. Four more taken updates -> T-cache ctr saturates at 11.
5. **Tag mismatch:** `fetch_pc`=0x140, `GHR`=0x010 (same cache index 0x40, tag 0x10) -> T-cache miss, `predict_taken`=0 (choice[0x50] = 01), `pred_cache_hit`=0.
6. **Reset mid-operation and same-cycle read/write:**
   - Assert `rst` while `upd_valid`=1 -> after release, the lookup of 0x100/0 returns 0/0.
   - Lookup of 0x100/0 in the same cycle as its first update -> returns the old value; the updated value appears the next cycle.
